// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU control path: FSM states, instruction
// field positions and the bit order of the ALU control word.
package hack_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_AINST,
    ST_MEMRD,
    ST_EXEC,
    ST_MEMWR
  } state_t;

  // Instruction field positions
  localparam int IR_CTYPE   = 15;
  localparam int IR_ABIT    = 12;
  localparam int IR_COMP_HI = 11;
  localparam int IR_COMP_LO = 6;
  localparam int IR_DEST_HI = 5;
  localparam int IR_DEST_LO = 3;
  localparam int IR_JUMP_HI = 2;
  localparam int IR_JUMP_LO = 0;

  // Destination bits inside the instruction word
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;

  // Jump bits inside the jump field: less-than, equal, greater-than
  localparam int JMP_LT = 2;
  localparam int JMP_EQ = 1;
  localparam int JMP_GT = 0;

  // ALU control word as driven on alu_ctl, msb first: {zx,nx,zy,ny,f,no}
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctl_t;

  localparam int ALU_CTL_W = $bits(alu_ctl_t);

  // First state after an instruction has been accepted.
  function automatic state_t decode_fetch(input logic ctype, input logic abit);
    if (!ctype)     return ST_AINST;
    else if (abit)  return ST_MEMRD;
    else            return ST_EXEC;
  endfunction

endpackage

// File: rtl/hack_jump_cond.sv
// Combinational jump decision from the instruction jump bits and ALU flags.
module hack_jump_cond
  import hack_pkg::*;
(
  input  logic [2:0] jump,
  input  logic       alu_zr,
  input  logic       alu_ng,
  output logic       jmp
);

  assign jmp = (jump[JMP_LT] & alu_ng)
             | (jump[JMP_EQ] & alu_zr)
             | (jump[JMP_GT] & ~alu_ng & ~alu_zr);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control unit: fetches one instruction, sequences data-memory
// read/write handshakes and issues A/D/PC write strobes in the commit cycle.
module hack_cpu_ctrl
  import hack_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  input  logic [15:0]          instr,
  output logic                 instr_ready,
  output logic                 mem_rd_req,
  input  logic                 mem_rd_ack,
  output logic                 mem_wr_req,
  input  logic                 mem_wr_ack,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic                 alu_y_sel,
  input  logic                 alu_zr,
  input  logic                 alu_ng,
  output logic                 load_a,
  output logic                 a_sel,
  output logic                 load_d,
  output logic                 pc_load,
  output logic                 pc_inc,
  output logic                 busy
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;
  alu_ctl_t    comp;
  logic        jmp;
  logic        commit;
  logic        unused_ir_bits;

  assign comp           = alu_ctl_t'(ir[IR_COMP_HI:IR_COMP_LO]);
  // The type bit is consumed at fetch and the two spare bits are don't-care.
  assign unused_ir_bits = ^ir[IR_CTYPE:IR_ABIT+1];

  hack_jump_cond u_jump_cond (
    .jump   (ir[IR_JUMP_HI:IR_JUMP_LO]),
    .alu_zr (alu_zr),
    .alu_ng (alu_ng),
    .jmp    (jmp)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; combinational blocks below use blocking ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && instr_valid) begin
        ir <= instr;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FETCH: if (instr_valid) state_nxt = decode_fetch(instr[IR_CTYPE], instr[IR_ABIT]);
      ST_AINST: state_nxt = ST_FETCH;
      ST_MEMRD: if (mem_rd_ack) state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = ir[DEST_M] ? ST_MEMWR : ST_FETCH;
      ST_MEMWR: if (mem_wr_ack) state_nxt = ST_FETCH;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  // Outputs are decoded from the registered state and ir; only the commit
  // strobes look at mem_wr_ack and the ALU flags within the same cycle.
  assign commit = (state == ST_EXEC  && !ir[DEST_M])
               || (state == ST_MEMWR && mem_wr_ack);

  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
    alu_ctl     = '0;
    alu_y_sel   = 1'b0;
    load_a      = 1'b0;
    a_sel       = 1'b0;
    load_d      = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    unique case (state)
      ST_FETCH: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      ST_AINST: begin
        load_a = 1'b1;
        pc_inc = 1'b1;
      end
      ST_MEMRD: begin
        mem_rd_req = 1'b1;
        alu_y_sel  = 1'b1;
      end
      ST_EXEC: begin
        alu_ctl   = comp;
        alu_y_sel = ir[IR_ABIT];
      end
      ST_MEMWR: begin
        alu_ctl    = comp;
        alu_y_sel  = ir[IR_ABIT];
        mem_wr_req = 1'b1;
      end
      default: begin
        instr_ready = 1'b0;
        busy        = 1'b0;
      end
    endcase
    if (commit) begin
      load_a  = ir[DEST_A];
      a_sel   = 1'b1;
      load_d  = ir[DEST_D];
      pc_load = jmp;
      pc_inc  = ~jmp;
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Randomized self-checking bench for hack_cpu_ctrl: each instruction is
// expanded into an expected cycle-by-cycle timeline from the instruction rules.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        mem_rd_req, mem_rd_ack;
  logic        mem_wr_req, mem_wr_ack;
  logic [5:0]  alu_ctl;
  logic        alu_y_sel, alu_zr, alu_ng;
  logic        load_a, a_sel, load_d, pc_load, pc_inc, busy;

  int n_pass   = 0;
  int n_checks = 0;

  typedef struct {
    bit          valid;
    logic [15:0] ins;
    bit          rd_ack;
    bit          wr_ack;
    bit          zr;
    bit          ng;
    logic [15:0] exp;
  } step_t;

  step_t steps[$];

  always #5 clk = ~clk;

  hack_cpu_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .mem_rd_req  (mem_rd_req),
    .mem_rd_ack  (mem_rd_ack),
    .mem_wr_req  (mem_wr_req),
    .mem_wr_ack  (mem_wr_ack),
    .alu_ctl     (alu_ctl),
    .alu_y_sel   (alu_y_sel),
    .alu_zr      (alu_zr),
    .alu_ng      (alu_ng),
    .load_a      (load_a),
    .a_sel       (a_sel),
    .load_d      (load_d),
    .pc_load     (pc_load),
    .pc_inc      (pc_inc),
    .busy        (busy)
  );

  // Output vector: {instr_ready, busy, rd_req, wr_req, alu_ctl[5:0],
  //                 y_sel, load_a, a_sel, load_d, pc_load, pc_inc}
  function automatic logic [15:0] mk(bit rdy, bit bsy, bit rd, bit wr, logic [5:0] ctl,
                                     bit ys, bit la, bit as, bit ld, bit pl, bit pi);
    return {rdy, bsy, rd, wr, ctl, ys, la, as, ld, pl, pi};
  endfunction

  function automatic logic [15:0] observed();
    return {instr_ready, busy, mem_rd_req, mem_wr_req, alu_ctl,
            alu_y_sel, load_a, a_sel, load_d, pc_load, pc_inc};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit pick(input int forced);
    return (forced < 0) ? bit'($urandom_range(0, 1)) : bit'(forced);
  endfunction

  // Jump taken when the ALU result's sign class (<0, =0, >0) is enabled.
  function automatic bit jump_taken(input logic [15:0] ins, input bit zr, input bit ng);
    bit lt, eq, gt;
    lt = ng;
    eq = zr;
    gt = !ng && !zr;
    return (ins[2] && lt) || (ins[1] && eq) || (ins[0] && gt);
  endfunction

  function automatic step_t busy_step(input int zr_f, input int ng_f);
    step_t s;
    s.valid  = bit'($urandom_range(0, 1));
    s.ins    = 16'($urandom);
    s.rd_ack = 1'b0;
    s.wr_ack = 1'b0;
    s.zr     = pick(zr_f);
    s.ng     = pick(ng_f);
    s.exp    = '0;
    return s;
  endfunction

  // Timeline of one instruction: idle fetch cycles, accepting fetch cycle,
  // then either the A-load cycle or read-wait / ALU / write-wait cycles.
  task automatic build(input logic [15:0] ins, input int nr, input int nw, input int idle,
                       input int zr_f, input int ng_f);
    step_t       s;
    logic [5:0]  ctl;
    bit          ys, j;
    logic [15:0] fetch_v;
    fetch_v = mk(1, 0, 0, 0, 6'd0, 0, 0, 0, 0, 0, 0);
    ctl = ins[11:6];
    ys  = ins[12];
    steps.delete();
    for (int i = 0; i < idle; i++) begin
      s = busy_step(zr_f, ng_f);
      s.valid = 1'b0;
      s.exp   = fetch_v;
      steps.push_back(s);
    end
    s = busy_step(zr_f, ng_f);
    s.valid = 1'b1;
    s.ins   = ins;
    s.exp   = fetch_v;
    steps.push_back(s);
    if (!ins[15]) begin
      s = busy_step(zr_f, ng_f);
      s.exp = mk(0, 1, 0, 0, 6'd0, 0, 1, 0, 0, 0, 1);
      steps.push_back(s);
      return;
    end
    if (ins[12]) begin
      for (int k = 0; k <= nr; k++) begin
        s = busy_step(zr_f, ng_f);
        s.rd_ack = (k == nr);
        s.exp    = mk(0, 1, 1, 0, 6'd0, 1, 0, 0, 0, 0, 0);
        steps.push_back(s);
      end
    end
    s = busy_step(zr_f, ng_f);
    if (ins[3]) begin
      s.exp = mk(0, 1, 0, 0, ctl, ys, 0, 0, 0, 0, 0);
      steps.push_back(s);
      for (int k = 0; k <= nw; k++) begin
        s = busy_step(zr_f, ng_f);
        s.wr_ack = (k == nw);
        j = jump_taken(ins, s.zr, s.ng);
        if (k == nw) s.exp = mk(0, 1, 0, 1, ctl, ys, ins[5], 1, ins[4], j, !j);
        else         s.exp = mk(0, 1, 0, 1, ctl, ys, 0, 0, 0, 0, 0);
        steps.push_back(s);
      end
    end else begin
      j = jump_taken(ins, s.zr, s.ng);
      s.exp = mk(0, 1, 0, 0, ctl, ys, ins[5], 1, ins[4], j, !j);
      steps.push_back(s);
    end
  endtask

  // Plays the timeline; abort_at >= 0 pulls reset during that step instead.
  task automatic run_instr(input string tag, input logic [15:0] ins, input int nr, input int nw,
                           input int idle, input int zr_f, input int ng_f, input int abort_at);
    build(ins, nr, nw, idle, zr_f, ng_f);
    foreach (steps[i]) begin
      @(negedge clk);
      instr_valid = steps[i].valid;
      instr       = steps[i].ins;
      mem_rd_ack  = steps[i].rd_ack;
      mem_wr_ack  = steps[i].wr_ack;
      alu_zr      = steps[i].zr;
      alu_ng      = steps[i].ng;
      if (i == abort_at) begin
        check($sformatf("%s_pre_rst", tag), observed(), steps[i].exp);
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        mem_rd_ack  = 1'b0;
        mem_wr_ack  = 1'b0;
        #1;
        check($sformatf("%s_in_rst", tag), observed() & 16'h7fff, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check($sformatf("%s_post_rst", tag), observed(), mk(1, 0, 0, 0, 6'd0, 0, 0, 0, 0, 0, 0));
        return;
      end
      #1;
      check($sformatf("%s_%0h_c%0d", tag, ins, i), observed(), steps[i].exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    mem_rd_ack  = 1'b0;
    mem_wr_ack  = 1'b0;
    alu_zr      = 1'b0;
    alu_ng      = 1'b0;
    #3;
    check("reset_outputs", observed() & 16'h7fff, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("after_reset", observed(), mk(1, 0, 0, 0, 6'd0, 0, 0, 0, 0, 0, 0));

    run_instr("a_instr",   16'h0015, 0, 0, 1, -1, -1, -1);
    run_instr("d_eq_a",    16'hEC10, 0, 0, 0, -1, -1, -1);
    run_instr("m_dplusm",  16'hF088, 2, 1, 0, -1, -1, -1);
    run_instr("jgt_pos",   16'hE301, 0, 0, 0,  0,  0, -1);
    run_instr("jgt_zero",  16'hE301, 0, 0, 0,  1,  0, -1);
    run_instr("jgt_neg",   16'hE301, 0, 0, 0,  0,  1, -1);
    for (int k = 0; k < 4; k++)
      run_instr("jmp",     16'hEA87, 0, 0, 0, -1, -1, -1);
    run_instr("nodest",    16'hEA80, 0, 0, 0, -1, -1, -1);
    run_instr("rst_memwr", 16'hF088, 0, 3, 0, -1, -1, 4);
    run_instr("rst_memrd", 16'hFC10, 3, 0, 0, -1, -1, 2);
    run_instr("a_again",   16'h7FFF, 0, 0, 0, -1, -1, -1);

    for (int n = 0; n < 80; n++) begin
      run_instr("rnd", 16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), -1, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
